mmio_clint_timer: RTL and testbench

//  Memory-mapped RISC-V machine-timer (CLINT subset) slave on the data MMIO bus behind the MMIO controller.

---
 rtl/mmio_clint_timer_pkg.sv | 46 ++++
 rtl/mmio_clint_timer_if.sv | 34 +++
 rtl/mmio_clint_timer_cmp.sv | 30 +++
 rtl/mmio_clint_timer.sv | 111 +++++++++++
 tb/tb_mmio_clint_timer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mmio_clint_timer_pkg.sv
// Shared definitions for the CLINT machine-timer MMIO slave.
//   basicparams          : bus width and common word types
//   memorymap            : CLINT window placement and register word offsets
//   mmio_clint_timer_pkg : register-select enum and offset decode helper
// Optional feature macro used by this block: CLINT_MTIP_EN (see mmio_clint_timer.sv).

package basicparams;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] UIntX;
  typedef logic [63:0]     UInt64;
endpackage : basicparams

package memorymap;
  localparam logic [31:0] CLINT_OFFSET = 32'h0200_0000;
  localparam logic [31:0] CLINT_END    = 32'h0200_000F;

  localparam logic [3:0] CLINT_MTIME_LO_OFF    = 4'h0;
  localparam logic [3:0] CLINT_MTIME_HI_OFF    = 4'h4;
  localparam logic [3:0] CLINT_MTIMECMP_LO_OFF = 4'h8;
  localparam logic [3:0] CLINT_MTIMECMP_HI_OFF = 4'hC;
endpackage : memorymap

package mmio_clint_timer_pkg;
  import memorymap::*;

  typedef enum logic [1:0] {
    SEL_MTIME_LO = 2'd0,
    SEL_MTIME_HI = 2'd1,
    SEL_CMP_LO   = 2'd2,
    SEL_CMP_HI   = 2'd3
  } reg_sel_e;

  // Map a byte offset inside the 16-byte window to a register; the low two
  // bits are masked because only full-word accesses exist.
  function automatic reg_sel_e decode_sel(input logic [3:0] i_off);
    logic [3:0] w_word_off;
    w_word_off = i_off & 4'hC;
    case (w_word_off)
      CLINT_MTIME_LO_OFF:    decode_sel = SEL_MTIME_LO;
      CLINT_MTIME_HI_OFF:    decode_sel = SEL_MTIME_HI;
      CLINT_MTIMECMP_LO_OFF: decode_sel = SEL_CMP_LO;
      CLINT_MTIMECMP_HI_OFF: decode_sel = SEL_CMP_HI;
      default:               decode_sel = SEL_MTIME_LO;
    endcase
  endfunction
endpackage : mmio_clint_timer_pkg

// File: rtl/mmio_clint_timer_if.sv
// Data-side MMIO request/response bundle between the MMIO controller
// (master) and a slave such as the CLINT timer.

interface mmio_clint_timer_if;
  import basicparams::*;

  logic req_ready;
  logic req_valid;
  UIntX req_addr;
  logic req_wen;
  UIntX req_wdata;
  logic resp_valid;
  UIntX resp_rdata;

  modport master (
    input  req_ready,
    output req_valid,
    output req_addr,
    output req_wen,
    output req_wdata,
    input  resp_valid,
    input  resp_rdata
  );

  modport slave (
    output req_ready,
    input  req_valid,
    input  req_addr,
    input  req_wen,
    input  req_wdata,
    output resp_valid,
    output resp_rdata
  );
endinterface : mmio_clint_timer_if

// File: rtl/mmio_clint_timer_cmp.sv
// clint_cmp_unit: unsigned 64-bit mtime >= mtimecmp compare, registered
// into the machine timer interrupt-pending flag. Used only when the top is
// built with CLINT_MTIP_EN.

module clint_cmp_unit
  import basicparams::*;
(
  input  logic  clk,
  input  logic  rst,
  input  UInt64 i_mtime,
  input  UInt64 i_mtimecmp,
  output logic  o_mtip
);

  logic w_expired;
  logic r_mtip;

  assign w_expired = (i_mtime >= i_mtimecmp);
  assign o_mtip    = r_mtip;

  // Register the compare result so mtip lags its inputs by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= w_expired;
    end
  end

endmodule : clint_cmp_unit

// File: rtl/mmio_clint_timer.sv
// mmio_clint_timer: CLINT subset on the data MMIO bus. mtime (counted
// outside) is read-only, mtimecmp is read/write, accessed as 32-bit words.
// Requests are always accepted; reads answer with a one-cycle pulse in the
// following cycle, writes produce no response.
// Optional macro CLINT_MTIP_EN: adds the registered mtip output.

module mmio_clint_timer
  import basicparams::*;
  import mmio_clint_timer_pkg::*;
#(
  parameter int FMAX_MHz = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_clint_timer_if.slave     bus,
  input  UInt64                 mtime,
  output UInt64                 mtimecmp
`ifdef CLINT_MTIP_EN
  ,
  output logic                  mtip
`endif
);

  if (FMAX_MHz < 1) begin : g_fmax_check
    $error("mmio_clint_timer: FMAX_MHz must be positive");
  end

  reg_sel_e       w_sel;
  logic           w_rd_accept;
  logic           w_wr_accept;
  UIntX           w_rd_data;
  logic [XLEN-5:0] w_addr_unused;

  UIntX r_cmp_lo;
  UIntX r_cmp_hi;
  logic r_resp_valid;
  UIntX r_resp_rdata;

  // Only offset bits [3:0] take part in decode.
  assign w_addr_unused = bus.req_addr[XLEN-1:4];

  assign bus.req_ready = 1'b1;
  assign w_sel         = decode_sel(bus.req_addr[3:0]);
  assign w_rd_accept   = bus.req_valid & ~bus.req_wen;
  assign w_wr_accept   = bus.req_valid &  bus.req_wen;

  assign mtimecmp       = {r_cmp_hi, r_cmp_lo};
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;

  // Read mux: mtime halves are sampled live, so a 64-bit read is two
  // independent snapshots and software deals with the carry.
  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      SEL_MTIME_LO: w_rd_data = mtime[31:0];
      SEL_MTIME_HI: w_rd_data = mtime[63:32];
      SEL_CMP_LO:   w_rd_data = r_cmp_lo;
      SEL_CMP_HI:   w_rd_data = r_cmp_hi;
      default:      w_rd_data = '0;
    endcase
  end

  // mtimecmp halves: all-ones at reset so no interrupt fires before software
  // programs a deadline; writes to mtime offsets fall through and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp_lo <= '1;
      r_cmp_hi <= '1;
    end else if (w_wr_accept) begin
      case (w_sel)
        SEL_CMP_LO: r_cmp_lo <= bus.req_wdata;
        SEL_CMP_HI: r_cmp_hi <= bus.req_wdata;
        default: begin
          r_cmp_lo <= r_cmp_lo;
          r_cmp_hi <= r_cmp_hi;
        end
      endcase
    end else begin
      r_cmp_lo <= r_cmp_lo;
      r_cmp_hi <= r_cmp_hi;
    end
  end

  // Read response: one-cycle valid pulse, data held between reads; reset
  // drops any response that would otherwise appear next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_resp_rdata <= w_rd_data;
      end else begin
        r_resp_rdata <= r_resp_rdata;
      end
    end
  end

`ifdef CLINT_MTIP_EN
  clint_cmp_unit u_cmp (
    .clk        (clk),
    .rst        (rst),
    .i_mtime    (mtime),
    .i_mtimecmp ({r_cmp_hi, r_cmp_lo}),
    .o_mtip     (mtip)
  );
`endif

endmodule : mmio_clint_timer

// File: tb/tb_mmio_clint_timer.sv
// Self-checking bench for mmio_clint_timer: a table of directed bus
// vectors applied one per cycle, plus hand-written sequences for reset
// during a request and (when CLINT_MTIP_EN is defined) the mtip timing.

module tb_mmio_clint_timer;
  import basicparams::*;

  logic  clk;
  logic  rst;
  UInt64 mtime;
  UInt64 mtimecmp;
`ifdef CLINT_MTIP_EN
  logic  mtip;
`endif

  int n_tests;
  int n_fail;

  mmio_clint_timer_if bus_if ();

  mmio_clint_timer #(.FMAX_MHz(27)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .mtime    (mtime),
    .mtimecmp (mtimecmp)
`ifdef CLINT_MTIP_EN
    ,
    .mtip     (mtip)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] mt;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic [63:0] exp_cmp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  localparam logic [63:0] MT_A = 64'h0000_0012_3456_789A;
  localparam logic [63:0] MT_B = 64'h0000_0012_3456_789B;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus_if.req_valid = v;
    bus_if.req_wen   = w;
    bus_if.req_addr  = a;
    bus_if.req_wdata = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    mtime   = 64'h0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // valid wen  addr          wdata         mtime  evalid erdata        ecmp
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,        64'h0, 1'b1, 32'hFFFF_FFFF, ONES};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,        64'h0, 1'b1, 32'hFFFF_FFFF, ONES};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        64'h0, 1'b0, 32'hFFFF_FFFF, ONES};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        MT_A,  1'b1, 32'h3456_789A, ONES};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        MT_A,  1'b1, 32'h0000_0012, ONES};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_1000, MT_A, 1'b0, 32'h0000_0012, 64'hFFFF_FFFF_0000_1000};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_000C, 32'h0,        MT_A,  1'b0, 32'h0000_0012, 64'h0000_0000_0000_1000};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, MT_A, 1'b0, 32'h0000_0012, 64'h0000_0000_0000_1000};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        MT_B,  1'b1, 32'h3456_789B, 64'h0000_0000_0000_1000};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,        MT_B,  1'b1, 32'h0000_1000, 64'h0000_0000_0000_1000};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,        MT_B,  1'b1, 32'h0000_0000, 64'h0000_0000_0000_1000};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        MT_B,  1'b1, 32'h0000_0012, 64'h0000_0000_0000_1000};
    vecs[12] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,        MT_B,  1'b0, 32'h0000_0012, 64'h0000_0000_0000_1000};
    vecs[13] = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0,        MT_B,  1'b1, 32'h0000_1000, 64'h0000_0000_0000_1000};
    vecs[14] = '{1'b1, 1'b1, 32'h1000_000C, 32'hCAFE_0001, MT_B, 1'b0, 32'h0000_1000, 64'hCAFE_0001_0000_1000};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_ABCD, MT_B, 1'b0, 32'h0000_1000, 64'hCAFE_0001_0000_1000};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,        MT_B,  1'b1, 32'hCAFE_0001, 64'hCAFE_0001_0000_1000};

    // Reset state, ready held high through reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready",  {63'h0, bus_if.req_ready},  64'h1);
    check("reset_valid",  {63'h0, bus_if.resp_valid}, 64'h0);
    check("reset_rdata",  {32'h0, bus_if.resp_rdata}, 64'h0);
    check("reset_cmp",    mtimecmp, ONES);
`ifdef CLINT_MTIP_EN
    check("reset_mtip",   {63'h0, mtip}, 64'h0);
`endif
    rst = 1'b0;

    // Table: inputs applied in one cycle, checked just after the closing edge
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      mtime = vecs[i].mt;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {63'h0, bus_if.resp_valid}, {63'h0, vecs[i].exp_valid});
      check($sformatf("v%0d_rdata", i), {32'h0, bus_if.resp_rdata}, {32'h0, vecs[i].exp_rdata});
      check($sformatf("v%0d_cmp", i),   mtimecmp, vecs[i].exp_cmp);
      check($sformatf("v%0d_ready", i), {63'h0, bus_if.req_ready}, 64'h1);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset arriving together with a read: no response, state reinitialised
    drive(1'b1, 1'b0, 32'h0000_000C, 32'h0);
    rst = 1'b1;
    #1;
    check("midrst_ready", {63'h0, bus_if.req_ready}, 64'h1);
    @(posedge clk);
    #1;
    check("midrst_valid", {63'h0, bus_if.resp_valid}, 64'h0);
    check("midrst_rdata", {32'h0, bus_if.resp_rdata}, 64'h0);
    check("midrst_cmp",   mtimecmp, ONES);
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    @(posedge clk);
    #1;
    check("postrst_valid", {63'h0, bus_if.resp_valid}, 64'h1);
    check("postrst_rdata", {32'h0, bus_if.resp_rdata}, 64'hFFFF_FFFF);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("postrst_pulse_end", {63'h0, bus_if.resp_valid}, 64'h0);

`ifdef CLINT_MTIP_EN
    // mtip rises one cycle after mtime reaches mtimecmp, falls one cycle
    // after mtimecmp moves beyond mtime
    mtime = 64'hFF;
    drive(1'b1, 1'b1, 32'h0000_0008, 32'h0000_0100);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 32'h0000_000C, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("mtip_cmp_set", mtimecmp, 64'h100);
    @(posedge clk);
    #1;
    check("mtip_below", {63'h0, mtip}, 64'h0);
    mtime = 64'h100;
    #1;
    check("mtip_lag", {63'h0, mtip}, 64'h0);
    @(posedge clk);
    #1;
    check("mtip_rise", {63'h0, mtip}, 64'h1);
    drive(1'b1, 1'b1, 32'h0000_000C, 32'h0000_0001);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("mtip_cmp_hi", mtimecmp, 64'h0000_0001_0000_0100);
    check("mtip_still_high", {63'h0, mtip}, 64'h1);
    @(posedge clk);
    #1;
    check("mtip_fall", {63'h0, mtip}, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mmio_clint_timer
